// File: rtl/ram_streamer_pkg.sv
// ram_streamer shared types: FSM states and output buffer depth.
// Optional looping support is enabled by defining RAM_STREAMER_LOOP_EN.
package ram_streamer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int OBUF_DEPTH = 2;

endpackage

// File: rtl/ram_streamer_obuf.sv
// Two-entry output FIFO holding {last, data}; push and pop may coincide.
// Head entry stays put until popped, so the stream side sees stable data.
module ram_streamer_obuf
   import ram_streamer_pkg::*;
#(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic [1:0]   occ
);

   logic [W-1:0] mem_q [OBUF_DEPTH];
   logic [W-1:0] mem_d [OBUF_DEPTH];
   logic         wr_q, wr_d;
   logic         rd_q, rd_d;
   logic [1:0]   occ_q, occ_d;
   logic         do_pop;

   always_comb begin
      mem_d  = mem_q;
      wr_d   = wr_q;
      rd_d   = rd_q;
      occ_d  = occ_q;
      do_pop = pop && (occ_q != 2'd0);
      if (push) begin
         mem_d[wr_q] = din;
         wr_d        = ~wr_q;
      end
      if (do_pop) begin
         rd_d = ~rd_q;
      end
      unique case ({push, do_pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < OBUF_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         occ_q <= 2'd0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         occ_q <= occ_d;
      end
   end

   assign dout = mem_q[rd_q];
   assign occ  = occ_q;

endmodule

// File: rtl/ram_streamer.sv
// Streams (addr, len) bursts out of a block RAM port as AXI-Stream.
// Define RAM_STREAMER_LOOP_EN to add the loop/stop repeat controls.
module ram_streamer
   import ram_streamer_pkg::*;
#(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [AWIDTH-1:0] cmd_addr,
   input  logic [AWIDTH-1:0] cmd_len_m1,
   input  logic              cmd_valid,
   output logic              cmd_ready,
`ifdef RAM_STREAMER_LOOP_EN
   input  logic              loop,
   input  logic              stop,
`endif
   output logic              ram_en,
   output logic [AWIDTH-1:0] ram_addr,
   input  logic [DWIDTH-1:0] ram_dout,
   output logic [DWIDTH-1:0] o_tdata,
   output logic              o_tlast,
   output logic              o_tvalid,
   input  logic              o_tready,
   output logic              busy
);

   state_t            state_q, state_d;
   logic [AWIDTH-1:0] start_q, start_d;
   logic [AWIDTH-1:0] len_q, len_d;
   logic [AWIDTH-1:0] cnt_q, cnt_d;
   logic              infl_q, infl_d;
   logic              infl_last_q, infl_last_d;
   logic [1:0]        occ;
   logic [2:0]        lvl;
   logic              pop;
   logic              final_issue;
   logic              restart;
   logic [DWIDTH:0]   buf_dout;

`ifdef RAM_STREAMER_LOOP_EN
   logic stop_q, stop_d;

   assign restart = loop && !(stop_q || stop);

   always_comb begin
      stop_d = stop_q || stop;
      if (state_q == IDLE) begin
         stop_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stop_q <= 1'b0;
      end else begin
         stop_q <= stop_d;
      end
   end
`else
   assign restart = 1'b0;
`endif

   assign pop         = o_tvalid && o_tready;
   // Words already owed to the buffer must fit after this cycle's pop.
   assign lvl         = {1'b0, occ} + {2'b00, infl_q};
   assign ram_en      = (state_q == READ) && (lvl < (3'd2 + {2'b00, pop}));
   assign ram_addr    = start_q + cnt_q;
   assign final_issue = ram_en && (cnt_q == len_q);

   always_comb begin
      state_d     = state_q;
      start_d     = start_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      infl_d      = ram_en;
      infl_last_d = final_issue;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               start_d = cmd_addr;
               len_d   = cmd_len_m1;
               cnt_d   = '0;
               state_d = READ;
            end
         end
         READ: begin
            if (ram_en) begin
               cnt_d = cnt_q + 1'b1;
            end
            if (final_issue) begin
               if (restart) begin
                  cnt_d = '0;
               end else begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Only the very last buffered word ends the command.
            if (pop && o_tlast && occ == 2'd1 && !infl_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         start_q     <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         infl_q      <= 1'b0;
         infl_last_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         start_q     <= start_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         infl_q      <= infl_d;
         infl_last_q <= infl_last_d;
      end
   end

   ram_streamer_obuf #(
      .W (DWIDTH + 1)
   ) u_obuf (
      .clk   (clk),
      .reset (reset),
      .push  (infl_q),
      .pop   (pop),
      .din   ({infl_last_q, ram_dout}),
      .dout  (buf_dout),
      .occ   (occ)
   );

   assign o_tdata   = buf_dout[DWIDTH-1:0];
   assign o_tlast   = buf_dout[DWIDTH];
   assign o_tvalid  = (occ != 2'd0);
   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ram_streamer.sv
// Scoreboard bench for ram_streamer: RAM model, queued expectations, monitors.
// Exercises the loop/stop path when RAM_STREAMER_LOOP_EN is defined.
module tb_ram_streamer;

   localparam int DW = 32;
   localparam int AW = 9;
   localparam int DEPTH = 1 << AW;

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
      int            rel;
   } beat_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] cmd_addr = '0;
   logic [AW-1:0] cmd_len_m1 = '0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          ram_en;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_dout = '0;
   logic [DW-1:0] o_tdata;
   logic          o_tlast;
   logic          o_tvalid;
   logic          o_tready = 1'b1;
   logic          busy;
`ifdef RAM_STREAMER_LOOP_EN
   logic          loop = 1'b0;
   logic          stop = 1'b0;
`endif

   logic [DW-1:0] mem [DEPTH];
   beat_t         exp_q[$];
   logic [AW-1:0] addr_q[$];
   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;
   int            cur_c0 = 0;
   bit            rnd_mode = 1'b0;
   bit            prev_stall = 1'b0;
   logic [DW-1:0] prev_d = '0;
   logic          prev_l = 1'b0;

   ram_streamer #(
      .DWIDTH (DW),
      .AWIDTH (AW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_addr   (cmd_addr),
      .cmd_len_m1 (cmd_len_m1),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
`ifdef RAM_STREAMER_LOOP_EN
      .loop       (loop),
      .stop       (stop),
`endif
      .ram_en     (ram_en),
      .ram_addr   (ram_addr),
      .ram_dout   (ram_dout),
      .o_tdata    (o_tdata),
      .o_tlast    (o_tlast),
      .o_tvalid   (o_tvalid),
      .o_tready   (o_tready),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (ram_en) ram_dout <= mem[ram_addr];
   end

   always @(posedge clk) begin
      #1;
      if (rnd_mode) o_tready = ($urandom_range(0, 1) == 1);
   end

   task automatic chk(input string nm, input logic [DW-1:0] act,
                      input logic [DW-1:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, expv);
      end
   endtask

   // Stream and RAM-address monitor
   always @(negedge clk) begin
      beat_t e;
      logic [AW-1:0] ea;
      int rel;
      rel = cyc - cur_c0;
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (!(o_tvalid && o_tdata === prev_d && o_tlast === prev_l)) begin
               failures++;
               $display("FAIL stall_hold actual=%0b/%0h/%0b required=1/%0h/%0b",
                        o_tvalid, o_tdata, o_tlast, prev_d, prev_l);
            end
         end
         if (o_tvalid && o_tready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL beat_extra actual=%0h required=none", o_tdata);
            end else begin
               e = exp_q.pop_front();
               if (o_tdata !== e.d || o_tlast !== e.l ||
                   (e.rel >= 0 && rel != e.rel)) begin
                  failures++;
                  $display("FAIL beat actual=%0h/last%0b/cyc%0d required=%0h/last%0b/cyc%0d",
                           o_tdata, o_tlast, rel, e.d, e.l, e.rel);
               end
            end
         end
         if (ram_en) begin
            checks++;
            if (addr_q.size() == 0) begin
               failures++;
               $display("FAIL ram_addr_extra actual=%0d required=none", ram_addr);
            end else begin
               ea = addr_q.pop_front();
               if (ram_addr !== ea) begin
                  failures++;
                  $display("FAIL ram_addr actual=%0d required=%0d", ram_addr, ea);
               end
            end
         end
         prev_stall = o_tvalid && !o_tready;
         prev_d     = o_tdata;
         prev_l     = o_tlast;
      end
   end

   task automatic check_reset_vals(input string nm);
      chk({nm, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
      chk({nm, "_ram_en"}, {31'd0, ram_en}, 32'd0);
      chk({nm, "_ram_addr"}, {23'd0, ram_addr}, 32'd0);
      chk({nm, "_tvalid"}, {31'd0, o_tvalid}, 32'd0);
      chk({nm, "_tlast"}, {31'd0, o_tlast}, 32'd0);
      chk({nm, "_tdata"}, o_tdata, 32'd0);
      chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   // Issue the command; returns once the accepting edge has passed.
   task automatic issue(input logic [AW-1:0] a, input logic [AW-1:0] l,
                        input int passes, input bit timed);
      int lim;
      int n;
      logic [AW-1:0] ad;
      @(posedge clk);
      #1;
      cmd_addr   = a;
      cmd_len_m1 = l;
      cmd_valid  = 1'b1;
      lim = 0;
      while (!cmd_ready && lim < 1000) begin
         @(posedge clk);
         #1;
         lim++;
      end
      @(posedge clk);
      #1;
      cur_c0    = cyc - 1;
      cmd_valid = 1'b0;
      n = int'(l) + 1;
      for (int p = 0; p < passes; p++) begin
         for (int i = 0; i < n; i++) begin
            ad = a + AW'(i);
            exp_q.push_back('{mem[ad], (i == n - 1), timed ? (3 + p * n + i) : -1});
            addr_q.push_back(ad);
         end
      end
   endtask

   task automatic run_burst(input logic [AW-1:0] a, input logic [AW-1:0] l,
                            input int passes, input bit timed, input int stop_at);
      int lim;
      int rel;
      bit seen;
      issue(a, l, passes, timed);
      lim  = 0;
      seen = 1'b0;
      while (!(cmd_ready && exp_q.size() == 0) && lim < 4000) begin
         @(negedge clk);
         rel = cyc - cur_c0;
`ifdef RAM_STREAMER_LOOP_EN
         stop = (rel == stop_at);
`endif
         if (timed && cmd_ready && !seen) begin
            seen = 1'b1;
            chk("cmd_ready_cycle", rel, passes * (int'(l) + 1) + 3);
         end
         lim++;
      end
`ifdef RAM_STREAMER_LOOP_EN
      stop = 1'b0;
`endif
      if (stop_at > 1000) $display("note stop_at unused");
      checks++;
      if (lim >= 4000) begin
         failures++;
         $display("FAIL burst_timeout actual=%0d_left required=0", exp_q.size());
         exp_q.delete();
         addr_q.delete();
      end else if (addr_q.size() != 0) begin
         failures++;
         $display("FAIL addr_left actual=%0d required=0", addr_q.size());
         addr_q.delete();
      end
   endtask

   initial begin
      logic [AW-1:0] ra;
      logic [AW-1:0] rl;
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      mem[5] = 32'hA5;
      for (int i = 0; i < 4; i++) mem[i] = i;

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check_reset_vals("rst");

      // single word, then 4-word, then wrap across the top of the RAM
      run_burst(9'd5, 9'd0, 1, 1'b1, -1);
      run_burst(9'd0, 9'd3, 1, 1'b1, -1);
      run_burst(9'd510, 9'd3, 1, 1'b1, -1);

      rnd_mode = 1'b1;
      run_burst(9'($urandom), 9'd63, 1, 1'b0, -1);
      for (int k = 0; k < 4; k++) begin
         run_burst(9'($urandom), 9'($urandom_range(0, 40)), 1, 1'b0, -1);
      end
      rnd_mode = 1'b0;
      #1;
      o_tready = 1'b1;

      // reset lands in cycle 5 of a 16-word burst
      issue(9'd100, 9'd15, 1, 1'b1);
      while (cyc - cur_c0 < 5) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      addr_q.delete();
      reset = 1'b0;
      @(negedge clk);
      check_reset_vals("midrst");
      run_burst(9'd300, 9'd7, 1, 1'b1, -1);

`ifdef RAM_STREAMER_LOOP_EN
      loop = 1'b1;
      run_burst(9'd40, 9'd2, 2, 1'b1, 5);
      loop = 1'b0;
`endif

      ra = 9'($urandom);
      rl = 9'($urandom_range(0, 20));
      run_burst(ra, rl, 1, 1'b1, -1);

      @(negedge clk);
      chk("final_idle", {31'd0, busy}, 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=done");
      $fatal(1, "timeout");
   end

endmodule
